serial_subtractor: RTL and testbench

- Bit-serial subtractor: computes a - b one bit per clock, LSB first, using a registered borrow.
- Built from a half-subtractor/full-subtractor cell; the inverse operation of the existing half adder.
- Sits beside the adder cells as the sequential arithmetic companion block.
- Start/busy/done handshake; the result is held stable until the next accepted start.

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle between a requester and the bit-serial subtractor.
// The master side issues start/a/b and observes status and result; the slave
// side is the subtractor itself.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, with a
// registered borrow. Each bit goes through a full-subtractor cell built from
// two half-subtractors. The result and final borrow are held until the next
// completion, so a consumer can read them at leisure after done.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;

    logic             d_bit;
    logic             b_next;
    logic [WIDTH-1:0] res_next;

    // Half-subtractor: {borrow, difference} of x - y.
    function automatic logic [1:0] half_sub(input logic x, input logic y);
        return {~x & y, x ^ y};
    endfunction

    // Full-subtractor as two chained half-subtractors; either stage may borrow.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bin);
        logic [1:0] s1;
        logic [1:0] s2;
        s1 = half_sub(ai, bi);
        s2 = half_sub(s1[0], bin);
        return {s1[1] | s2[1], s2[0]};
    endfunction

    // Difference/borrow cell on the current operand LSBs and the shifted result.
    always_comb begin
        {b_next, d_bit} = full_sub(a_sr[0], b_sr[0], borrow);
        res_next        = {d_bit, res_sr[WIDTH-1:1]};
    end

    // Control FSM and datapath; outputs are registered and change only on
    // entry to DONE (result) or on state transitions (status).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_sr         <= '0;
            b_sr         <= '0;
            res_sr       <= '0;
            borrow       <= 1'b0;
            cnt          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    borrow <= b_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        diff_q       <= res_next;
                        borrow_out_q <= b_next;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a stimulus process pushes the
// expected result of each accepted operation into a scoreboard queue and a
// monitor pops and compares whenever done is presented.
`timescale 1ns/100ps
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
    } exp_t;

    logic clk;
    logic rst_n;

    serial_subtractor_if #(.WIDTH(W)) bus_if ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int           checks;
    int           errors;
    exp_t         sb[$];
    logic [W-1:0] held_diff;
    logic         held_bo;
    logic         prev_done;

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain unsigned arithmetic, result taken modulo 2^W.
    function automatic exp_t refModel(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t        e;
        longint      dif;
        logic [63:0] m;
        dif  = longint'(av) - longint'(bv);
        m    = 64'(dif);
        e.d  = m[W-1:0];
        e.bo = (av < bv);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: status sanity every cycle, result compare on done, holding otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("busy_and_done", {63'd0, bus_if.busy & bus_if.done}, 64'd0);
            if (bus_if.done) begin
                checkOutput("done_width", {63'd0, prev_done}, 64'd0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("diff", 64'(bus_if.diff), 64'(e.d));
                    checkOutput("borrow_out", {63'd0, bus_if.borrow_out}, {63'd0, e.bo});
                    held_diff = e.d;
                    held_bo   = e.bo;
                end
            end else begin
                checkOutput("diff_hold", 64'(bus_if.diff), 64'(held_diff));
                checkOutput("borrow_hold", {63'd0, bus_if.borrow_out}, {63'd0, held_bo});
            end
            prev_done = bus_if.done;
        end
    end

    // Wait for done on negedges; reports cycles elapsed and busy-high cycles.
    task automatic waitDone(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (bus_if.busy) busy_cycles++;
            if (bus_if.done) break;
            if (cycles > 4 * W) begin
                checkOutput("done_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    // Wait on a negedge until the DUT is idle, bounded.
    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus_if.busy || bus_if.done) begin
            @(negedge clk);
            n++;
            if (n > 4 * W) begin
                checkOutput("idle_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    // One full operation: start for one cycle, scramble operands, then time it.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
        int cyc;
        int bc;
        waitIdle();
        bus_if.start = 1'b1;
        bus_if.a     = av;
        bus_if.b     = bv;
        sb.push_back(refModel(av, bv));
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.a     = W'($urandom);
        bus_if.b     = W'($urandom);
        waitDone(cyc, bc);
        checkOutput("latency", 64'(cyc), 64'(W + 1));
        checkOutput("busy_cycles", 64'(bc), 64'(W));
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int cyc;
        int bc;
        checks       = 0;
        errors       = 0;
        held_diff    = '0;
        held_bo      = 1'b0;
        prev_done    = 1'b0;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;

        #12;
        checkOutput("reset_busy", {63'd0, bus_if.busy}, 64'd0);
        checkOutput("reset_done", {63'd0, bus_if.done}, 64'd0);
        checkOutput("reset_diff", 64'(bus_if.diff), 64'd0);
        checkOutput("reset_borrow", {63'd0, bus_if.borrow_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases including wrap and equality.
        applyStimulus(8'h05, 8'h03);
        applyStimulus(8'h03, 8'h05);
        applyStimulus(8'h00, 8'h01);
        applyStimulus(8'hFF, 8'hFF);
        applyStimulus(8'h80, 8'h7F);
        applyStimulus(8'h00, 8'hFF);
        applyStimulus(8'hFF, 8'h00);

        // Start held high: operands sampled only on accepting edges, period W+2.
        waitIdle();
        bus_if.start = 1'b1;
        bus_if.a     = 8'h9C;
        bus_if.b     = 8'h3A;
        sb.push_back(refModel(8'h9C, 8'h3A));
        @(posedge clk);
        #1;
        bus_if.a = 8'h11;
        bus_if.b = 8'hEE;
        waitDone(cyc, bc);
        checkOutput("held_latency", 64'(cyc), 64'(W + 1));
        bus_if.a = 8'h21;
        bus_if.b = 8'h64;
        sb.push_back(refModel(8'h21, 8'h64));
        fork
            waitDone(cyc, bc);
            begin
                repeat (2) @(posedge clk);
                #1;
                bus_if.a = W'($urandom);
                bus_if.b = W'($urandom);
            end
        join
        checkOutput("held_period", 64'(cyc), 64'(W + 2));
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("no_restart", {63'd0, bus_if.busy}, 64'd0);

        // Asynchronous reset in the middle of SHIFT aborts with no done.
        waitIdle();
        bus_if.start = 1'b1;
        bus_if.a     = 8'h77;
        bus_if.b     = 8'h12;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #0.5;
        checkOutput("abort_busy", {63'd0, bus_if.busy}, 64'd0);
        checkOutput("abort_done", {63'd0, bus_if.done}, 64'd0);
        checkOutput("abort_diff", 64'(bus_if.diff), 64'd0);
        checkOutput("abort_borrow", {63'd0, bus_if.borrow_out}, 64'd0);
        held_diff = '0;
        held_bo   = 1'b0;
        prev_done = 1'b0;
        #0.5;
        rst_n = 1'b1;
        repeat (2 * W) @(negedge clk);
        applyStimulus(8'h44, 8'h45);

        // Random sweep.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(W'($urandom), W'($urandom));
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
